// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its surroundings: instruction
// memory port, decode-side hazard/redirect controls and IF/ID outputs.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] pc;
  logic        misalign_err;
  logic        range_err;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  stall,
    input  redirect_en,
    input  redirect_pc,
    output if_id_instr,
    output if_id_pc4,
    output if_id_valid,
    output pc,
    output misalign_err,
    output range_err,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output stall,
    output redirect_en,
    output redirect_pc,
    input  if_id_instr,
    input  if_id_pc4,
    input  if_id_valid,
    input  pc,
    input  misalign_err,
    input  range_err,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction
// memory and fills the IF/ID register with fetch, hold and flush behaviour.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 4096,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset_n,
  fetch_unit_if.master bus
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        misalign_q;
  logic        range_q;
  logic [31:0] count_q;

  logic [31:0] pc4;
  logic [31:0] jmp_tgt;
  logic        jmp_hit;
  logic        out_of_range;

  assign pc4          = pc_q + 32'd4;
  assign jmp_hit      = (bus.imem_instr[31:26] == 6'b000010);
  assign jmp_tgt      = {pc4[31:28], bus.imem_instr[25:0], 2'b00};
  assign out_of_range = ({2'b00, pc_q[31:2]} >= IMEM_WORDS);

  // Priority: reset, then redirect (beats stall), then stall, then fetch.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values of its neighbours, independent of statement order.
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      if (out_of_range) range_q <= 1'b1;

      if (bus.redirect_en) begin
        pc_q    <= {bus.redirect_pc[31:2], 2'b00};
        instr_q <= NOP_INSTR;
        pc4_q   <= 32'd0;
        valid_q <= 1'b0;
        if (bus.redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
      end else if (!bus.stall) begin
        instr_q <= bus.imem_instr;
        pc4_q   <= pc4;
        valid_q <= 1'b1;
        count_q <= count_q + 32'd1;
        pc_q    <= jmp_hit ? jmp_tgt : pc4;
      end
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.if_id_instr  = instr_q;
  assign bus.if_id_pc4    = pc4_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.range_err    = range_q;
  assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/redirect/reset traffic compared against a cycle-level reference model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS = 4096;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .IMEM_WORDS(IMEM_WORDS),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Instruction memory: word index taken from address bits [13:2].
  logic [31:0] mem [0:4095];
  always_comb bus.imem_instr = mem[bus.imem_addr[13:2]];

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_mis, m_rng;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] non_jump();
    logic [31:0] w;
    w = $urandom;
    while (w[31:26] == 6'b000010) w = $urandom;
    return w;
  endfunction

  task automatic check_all();
    check("pc", bus.pc, m_pc);
    check("imem_addr", bus.imem_addr, m_pc);
    check("if_id_instr", bus.if_id_instr, m_instr);
    check("if_id_pc4", bus.if_id_pc4, m_pc4);
    check("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, m_valid});
    check("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_mis});
    check("range_err", {31'd0, bus.range_err}, {31'd0, m_rng});
    check("fetch_count", bus.fetch_count, m_cnt);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 0;
    m_valid = 0; m_mis = 0; m_rng = 0; m_cnt = 0;
  endtask

  task automatic do_reset(input logic s, input logic re);
    reset_n = 1'b0;
    bus.stall = s;
    bus.redirect_en = re;
    bus.redirect_pc = $urandom;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_all();
  endtask

  // One clock: apply inputs, advance the model by the stage's rules, compare.
  task automatic step(input logic s, input logic re, input logic [31:0] rpc);
    logic [31:0] ins;
    bus.stall = s;
    bus.redirect_en = re;
    bus.redirect_pc = rpc;
    if (m_pc / 4 >= IMEM_WORDS) m_rng = 1;
    if (re) begin
      m_pc = rpc - (rpc % 4);
      m_instr = NOP_INSTR; m_pc4 = 0; m_valid = 0;
      if (rpc % 4 != 0) m_mis = 1;
    end else if (!s) begin
      ins = mem[(m_pc / 4) % 4096];
      m_instr = ins;
      m_pc4 = m_pc + 4;
      m_valid = 1;
      m_cnt = m_cnt + 1;
      if (ins / 32'h0400_0000 == 2)
        m_pc = ((m_pc + 4) & 32'hF000_0000) + (ins % 32'h0400_0000) * 4;
      else
        m_pc = m_pc + 4;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    bus.stall = 0; bus.redirect_en = 0; bus.redirect_pc = 0;
    for (int i = 0; i < 4096; i++) mem[i] = non_jump();
    mem[5] = 32'h0800_0002;

    // Reset, including a reset asserted alongside stall and redirect.
    do_reset(1'b1, 1'b1);

    // Sequential fetch of mem[0..2].
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check("seq_pc", bus.pc, 32'h0000_000C);
    check("seq_count", bus.fetch_count, 32'd3);
    check("seq_pc4", bus.if_id_pc4, 32'h0000_000C);

    // Jump at 0x14 lands on 0x8 with the j passed to decode.
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check("jmp_pc", bus.pc, 32'h0000_0008);
    check("jmp_instr", bus.if_id_instr, 32'h0800_0002);
    check("jmp_pc4", bus.if_id_pc4, 32'h0000_0018);

    // Stall holds everything; fetch resumes at 0x8.
    step(1, 0, 0);
    step(1, 0, 0);
    check("stall_count", bus.fetch_count, 32'd6);
    step(0, 0, 0);
    check("resume_instr", bus.if_id_instr, mem[2]);

    // Redirect beats stall, then mem[9] is fetched.
    step(1, 1, 32'h0000_0024);
    check("redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
    step(0, 0, 0);
    check("redir_fetch", bus.if_id_instr, mem[9]);

    // Misaligned redirect sets sticky error, cleared only by reset.
    step(0, 1, 32'h0000_0022);
    check("mis_pc", bus.pc, 32'h0000_0020);
    for (int i = 0; i < 3; i++) step(i == 1, 0, 0);
    check("mis_sticky", {31'd0, bus.misalign_err}, 32'd1);
    do_reset(1'b0, 1'b1);

    // Out-of-range PC and wrap at the top of the address space.
    step(0, 1, 32'h0000_4000);
    step(0, 0, 0);
    check("range_set", {31'd0, bus.range_err}, 32'd1);
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    check("wrap_pc", bus.pc, 32'h0000_0000);
    check("wrap_pc4", bus.if_id_pc4, 32'h0000_0000);

    // Random traffic with a sprinkling of jumps in memory.
    for (int i = 0; i < 4096; i++)
      if ($urandom_range(0, 19) == 0) mem[i] = {6'b000010, 26'($urandom_range(0, 4095))};
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                32'($urandom_range(0, 32'h0000_5FFF)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
